// File: rtl/wb_rr_arbiter_if.sv
// Bundle of master-side and slave-side Wishbone signals around the arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS   = 2,
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32
);
    logic [NUM_MASTERS-1:0]               m_cyc_i;
    logic [NUM_MASTERS-1:0]               m_stb_i;
    logic [NUM_MASTERS-1:0]               m_we_i;
    logic [4*NUM_MASTERS-1:0]             m_sel_i;
    logic [WB_ADDR_WIDTH*NUM_MASTERS-1:0] m_adr_i;
    logic [WB_DATA_WIDTH*NUM_MASTERS-1:0] m_dat_i;
    logic [WB_DATA_WIDTH-1:0]             m_dat_o;
    logic [NUM_MASTERS-1:0]               m_ack_o;
    logic [NUM_MASTERS-1:0]               m_err_o;
    logic                                 s_cyc_o;
    logic                                 s_stb_o;
    logic                                 s_we_o;
    logic [3:0]                           s_sel_o;
    logic [WB_ADDR_WIDTH-1:0]             s_adr_o;
    logic [WB_DATA_WIDTH-1:0]             s_dat_o;
    logic [WB_DATA_WIDTH-1:0]             s_dat_i;
    logic                                 s_ack_i;
    logic                                 s_err_i;
    logic [NUM_MASTERS-1:0]               grant_o;
    logic                                 timeout_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output grant_o, timeout_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: N masters onto one slave port,
// with a stall watchdog that turns a hung slave into an err response.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    wb_rr_arbiter_if.slave bus
);
    localparam int NM = NUM_MASTERS;
    localparam int DW = WB_DATA_WIDTH;
    localparam int AW = WB_ADDR_WIDTH;
    localparam int IW = $clog2(NM);
    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ?
                                      CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [NM-1:0] ONE = NM'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TMO  = 2'd2
    } state_t;

    state_t        r_state;
    logic [NM-1:0] r_grant;
    logic [IW-1:0] r_last;
    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    logic          w_found;
    logic [IW-1:0] w_nidx;
    logic          w_busy;
    logic          w_tmo;
    logic          w_gcyc;
    logic          w_gstb;
    logic          w_arb;
    logic          w_stall;
    logic [3:0]    w_sel;
    logic [AW-1:0] w_adr;
    logic [DW-1:0] w_dat;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_nidx  = '0;
        for (int i = 1; i <= NM; i++) begin
            if (!w_found && bus.m_cyc_i[(int'(r_last) + i) % NM]) begin
                w_found = 1'b1;
                w_nidx  = IW'((int'(r_last) + i) % NM);
            end
        end
    end

    always_comb begin
        w_sel = '0;
        w_adr = '0;
        w_dat = '0;
        for (int i = 0; i < NM; i++) begin
            if (r_grant[i]) begin
                w_sel = w_sel | bus.m_sel_i[4*i +: 4];
                w_adr = w_adr | bus.m_adr_i[AW*i +: AW];
                w_dat = w_dat | bus.m_dat_i[DW*i +: DW];
            end
        end
    end

    assign w_busy  = (r_state == ST_BUSY);
    assign w_tmo   = (r_state == ST_TMO);
    assign w_gcyc  = |(bus.m_cyc_i & r_grant);
    assign w_gstb  = |(bus.m_stb_i & r_grant);
    assign w_arb   = (r_state == ST_IDLE) || (w_busy && !w_gcyc);
    assign w_stall = bus.s_stb_o && !bus.s_ack_i && !bus.s_err_i;

    assign bus.s_cyc_o   = w_gcyc && w_busy;
    assign bus.s_stb_o   = w_gcyc && w_gstb && w_busy;
    assign bus.s_we_o    = |(bus.m_we_i & r_grant);
    assign bus.s_sel_o   = w_sel;
    assign bus.s_adr_o   = w_adr;
    assign bus.s_dat_o   = w_dat;
    assign bus.m_dat_o   = bus.s_dat_i;
    assign bus.m_ack_o   = (w_busy && bus.s_ack_i) ? r_grant : '0;
    assign bus.m_err_o   = ((w_busy && bus.s_err_i) || w_tmo) ?
                           r_grant : '0;
    assign bus.grant_o   = r_grant;
    assign bus.timeout_o = r_timeout;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_last    <= IW'(NM - 1);
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_arb) begin
                r_cnt <= '0;
                if (w_found) begin
                    r_grant <= ONE << w_nidx;
                    r_last  <= w_nidx;
                    r_state <= ST_BUSY;
                end else begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            end else if (w_tmo) begin
                r_cnt   <= '0;
                r_state <= ST_BUSY;
            end else if (TIMEOUT_CYCLES > 0 && w_stall) begin
                // The stall that completes the budget moves straight to TMO.
                if (r_cnt == LIMIT) begin
                    r_cnt     <= '0;
                    r_timeout <= 1'b1;
                    r_state   <= ST_TMO;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomised bench for wb_rr_arbiter against a transaction-level model
// of grant rotation, response routing and the stall watchdog.
module tb_wb_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    int   mg;
    int   mlast;
    int   mstall;
    bit   mtmo;

    wb_rr_arbiter_if #(
        .NUM_MASTERS(N), .WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW)
    ) bus ();

    wb_rr_arbiter #(
        .NUM_MASTERS(N), .WB_DATA_WIDTH(DW),
        .WB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mg     = -1;
        mlast  = N - 1;
        mstall = 0;
        mtmo   = 0;
    endtask

    task automatic compare();
        bit            busy;
        logic [N-1:0]  eg;
        logic [3:0]    esel;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat;
        logic          ewe;
        logic          ecyc;
        logic          estb;
        busy = (mg >= 0) && !mtmo;
        eg   = (mg >= 0) ? N'(1) << mg : '0;
        esel = '0;
        eadr = '0;
        edat = '0;
        ewe  = 1'b0;
        ecyc = 1'b0;
        estb = 1'b0;
        if (mg >= 0) begin
            esel = bus.m_sel_i[4*mg +: 4];
            eadr = bus.m_adr_i[AW*mg +: AW];
            edat = bus.m_dat_i[DW*mg +: DW];
            ewe  = bus.m_we_i[mg];
            ecyc = busy && bus.m_cyc_i[mg];
            estb = ecyc && bus.m_stb_i[mg];
        end
        check("grant",   bus.grant_o,   eg);
        check("timeout", bus.timeout_o, mtmo);
        check("s_cyc",   bus.s_cyc_o,   ecyc);
        check("s_stb",   bus.s_stb_o,   estb);
        check("s_we",    bus.s_we_o,    ewe);
        check("s_sel",   bus.s_sel_o,   esel);
        check("s_adr",   bus.s_adr_o,   eadr);
        check("s_dat",   bus.s_dat_o,   edat);
        check("m_ack",   bus.m_ack_o,
              (busy && bus.s_ack_i) ? eg : '0);
        check("m_err",   bus.m_err_o,
              (mtmo || (busy && bus.s_err_i)) ? eg : '0);
        check("m_dat",   bus.m_dat_o,   bus.s_dat_i);
    endtask

    // One clock of the reference: rotation, hold and watchdog rules.
    task automatic model_step();
        if (mtmo) begin
            mtmo   = 0;
            mstall = 0;
        end else if (mg < 0 || !bus.m_cyc_i[mg]) begin
            mg     = -1;
            mstall = 0;
            for (int k = 1; k <= N; k++) begin
                if (mg < 0 && bus.m_cyc_i[(mlast + k) % N])
                    mg = (mlast + k) % N;
            end
            if (mg >= 0) mlast = mg;
        end else if (bus.m_stb_i[mg] && !bus.s_ack_i && !bus.s_err_i) begin
            mstall++;
            if (mstall == T) begin
                mtmo   = 1;
                mstall = 0;
            end
        end else begin
            mstall = 0;
        end
    endtask

    task automatic step(input logic [N-1:0] c, input logic [N-1:0] s,
                        input logic a, input logic e);
        bus.m_cyc_i = c;
        bus.m_stb_i = s;
        bus.m_we_i  = N'($urandom);
        bus.m_sel_i = 16'($urandom);
        for (int i = 0; i < N; i++) begin
            bus.m_adr_i[AW*i +: AW] = $urandom;
            bus.m_dat_i[DW*i +: DW] = $urandom;
        end
        bus.s_dat_i = $urandom;
        bus.s_ack_i = a;
        bus.s_err_i = e;
        #1;
        compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] rc;
        logic [N-1:0] rs;
        logic         ra;
        logic         re;
        int           cur;
        checks   = 0;
        failures = 0;
        clk      = 0;
        rst_n    = 0;
        bus.m_cyc_i = 4'b0011;
        bus.m_stb_i = 4'b0011;
        bus.m_we_i  = '0;
        bus.m_sel_i = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = 1'b1;
        bus.s_err_i = 1'b0;
        model_reset();
        #22;
        check("rst_grant", bus.grant_o, 0);
        check("rst_scyc",  bus.s_cyc_o, 0);
        check("rst_ack",   bus.m_ack_o, 0);
        check("rst_dat",   bus.m_dat_o, 0);
        @(negedge clk);
        rst_n = 1;
        step(4'b0011, 4'b0011, 0, 0);
        check("rel_grant", bus.grant_o, 4'b0001);

        // Back-to-back contention between m0 and m1.
        for (int i = 0; i < 4; i++) begin
            cur = i % 2;
            step(4'b0011, 4'b0011, 1, 0);
            step(4'b0011 & ~(4'b1 << cur), 4'b0011, 0, 0);
            check("alt_grant", bus.grant_o, 4'b1 << (1 - cur));
        end

        // Wrap from master 3 back to master 0.
        step(4'b0000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        step(4'b1000, 4'b1000, 0, 0);
        check("m3_grant", bus.grant_o, 4'b1000);
        step(4'b0000, 4'b0000, 0, 0);
        step(4'b1001, 4'b1001, 0, 0);
        check("wrap_grant", bus.grant_o, 4'b0001);

        // Watchdog: eight stall cycles then forced err.
        step(4'b0000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        for (int i = 0; i < 9; i++) step(4'b0001, 4'b0001, 0, 0);
        #1;
        check("tmo_pulse", bus.timeout_o, 1);
        check("tmo_scyc",  bus.s_cyc_o,   0);
        check("tmo_err",   bus.m_err_o,   4'b0001);
        step(4'b0000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);

        // Ack on the eighth stall cycle beats the watchdog.
        for (int i = 0; i < 8; i++) step(4'b0001, 4'b0001, 0, 0);
        step(4'b0001, 4'b0001, 1, 0);
        #1;
        check("race_tmo", bus.timeout_o, 0);
        check("race_grant", bus.grant_o, 4'b0001);
        step(4'b0000, 4'b0000, 0, 0);

        rc = '0;
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) rc[i] = ~rc[i];
            rs = rc & N'($urandom);
            if ((n / 400) % 2 == 1) ra = ($urandom_range(15) == 0);
            else                    ra = ($urandom_range(1) == 0);
            re = ($urandom_range(15) == 0);
            step(rc, rs, ra, re);
        end

        // Asynchronous reset in the middle of a granted cycle.
        step(4'b0001, 4'b0001, 0, 0);
        step(4'b0001, 4'b0001, 0, 0);
        bus.s_ack_i = 1'b1;
        #2;
        rst_n = 0;
        #1;
        check("arst_scyc",  bus.s_cyc_o, 0);
        check("arst_grant", bus.grant_o, 0);
        check("arst_ack",   bus.m_ack_o, 0);
        check("arst_err",   bus.m_err_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int n = 0; n < 200; n++) begin
            rc = N'($urandom);
            step(rc, rc, 1'($urandom), 1'($urandom_range(7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
